// File: rtl/serial_sub_flags.sv
// Bit-serial WIDTH-bit subtractor z = x - y (LSB first) with sign/zero/overflow/borrow/parity flags.
// Latency: result and flags load WIDTH edges after the accepting edge; one op per WIDTH+1 cycles.
// Backpressure: start is sampled only while idle; requests while busy are dropped, not queued.
module serial_sub_flags #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] z,
    output logic             sign,
    output logic             zero,
    output logic             overflow,
    output logic             carry,
    output logic             parity
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [0:0]       state;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] r;
    logic             borrow;
    logic [CW-1:0]    cnt;
    logic             xmsb;
    logic             ymsb;

    logic             d;
    logic             borrow_nxt;
    logic [WIDTH-1:0] r_nxt;

    always_comb begin
        d          = a[0] ^ b[0] ^ borrow;
        borrow_nxt = (~a[0] & b[0]) | (~(a[0] ^ b[0]) & borrow);
        // new difference bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts
        r_nxt      = (r >> 1) | {d, {(WIDTH-1){1'b0}}};
    end

    assign busy = (state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a        <= '0;
            b        <= '0;
            r        <= '0;
            borrow   <= 1'b0;
            cnt      <= '0;
            xmsb     <= 1'b0;
            ymsb     <= 1'b0;
            done     <= 1'b0;
            z        <= '0;
            sign     <= 1'b0;
            zero     <= 1'b0;
            overflow <= 1'b0;
            carry    <= 1'b0;
            parity   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    a      <= x;
                    b      <= y;
                    r      <= '0;
                    borrow <= 1'b0;
                    cnt    <= '0;
                    xmsb   <= x[WIDTH-1];
                    ymsb   <= y[WIDTH-1];
                    state  <= RUN;
                end
            end else begin
                a      <= a >> 1;
                b      <= b >> 1;
                r      <= r_nxt;
                borrow <= borrow_nxt;
                cnt    <= cnt + 1'b1;
                if (cnt == LAST) begin
                    // operand registers are shifted out by now, so overflow uses the saved MSBs
                    z        <= r_nxt;
                    sign     <= d;
                    zero     <= ~|r_nxt;
                    overflow <= (xmsb ^ ymsb) & (d ^ xmsb);
                    carry    <= borrow_nxt;
                    parity   <= ~^r_nxt;
                    done     <= 1'b1;
                    cnt      <= '0;
                    state    <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_sub_flags.sv
// Directed bench for serial_sub_flags: flag vectors, handshake timing, restart and async reset.
module tb_serial_sub_flags;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] x;
    logic [15:0] y;
    logic        busy;
    logic        done;
    logic [15:0] z;
    logic        sign;
    logic        zero;
    logic        overflow;
    logic        carry;
    logic        parity;
    logic [4:0]  flags;

    int passed = 0;
    int total  = 0;

    // last result the bench expects to be held on z / flags
    logic [15:0] hold_z = 16'h0000;
    logic [4:0]  hold_f = 5'b00000;

    serial_sub_flags #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .x        (x),
        .y        (y),
        .busy     (busy),
        .done     (done),
        .z        (z),
        .sign     (sign),
        .zero     (zero),
        .overflow (overflow),
        .carry    (carry),
        .parity   (parity)
    );

    assign flags = {sign, zero, overflow, carry, parity};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // counts edges until done; every non-done cycle must show busy and the held result
    task automatic wait_done(input string tag);
        int  n = 0;
        int  unstable = 0;
        bit  got = 0;
        for (int i = 1; i <= 40 && !got; i++) begin
            @(posedge clk); #1;
            n = i;
            if (done) got = 1;
            else if (z !== hold_z || flags !== hold_f || busy !== 1'b1) unstable++;
        end
        chk({tag, "_latency"}, n, 16);
        chk({tag, "_stable"}, unstable, 0);
    endtask

    // flags expected as {sign, zero, overflow, carry, parity}
    task automatic run_op(input string tag, input logic [15:0] xv, input logic [15:0] yv,
                          input logic [15:0] ez, input logic [4:0] ef);
        x = xv; y = yv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        wait_done(tag);
        chk({tag, "_z"}, z, ez);
        chk({tag, "_flags"}, flags, ef);
        chk({tag, "_busy_low"}, busy, 0);
        hold_z = ez; hold_f = ef;
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, done, 0);
    endtask

    initial begin
        int ndone;
        rst_n = 1'b0; start = 1'b0; x = '0; y = '0;
        #2;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_z", z, 16'h0000);
        chk("reset_flags", flags, 5'b00000);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("sub_5_3",      16'h0005, 16'h0003, 16'h0002, 5'b00000);
        run_op("sub_equal",    16'h1234, 16'h1234, 16'h0000, 5'b01001);
        run_op("sub_0_1",      16'h0000, 16'h0001, 16'hffff, 5'b10011);
        run_op("sub_8000_1",   16'h8000, 16'h0001, 16'h7fff, 5'b00100);
        run_op("sub_7fff_ffff",16'h7fff, 16'hffff, 16'h8000, 5'b10110);

        // async reset in the middle of a run
        x = 16'h0005; y = 16'h0003; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("midrun_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_z", z, 16'h0000);
        chk("arst_flags", flags, 5'b00000);
        #2 rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        chk("arst_no_done", ndone, 0);
        hold_z = 16'h0000; hold_f = 5'b00000;
        run_op("after_reset", 16'h0005, 16'h0003, 16'h0002, 5'b00000);

        // start held high, operands changed mid-run, back-to-back restart
        x = 16'h0005; y = 16'h0003; start = 1'b1;
        @(posedge clk); #1;
        chk("hold_busy", busy, 1);
        x = 16'hffff; y = 16'hffff;
        wait_done("hold_run1");
        chk("hold_run1_z", z, 16'h0002);
        chk("hold_run1_flags", flags, 5'b00000);
        hold_z = 16'h0002; hold_f = 5'b00000;
        @(posedge clk); #1;
        chk("restart_busy", busy, 1);
        chk("restart_done_low", done, 0);
        start = 1'b0;
        wait_done("hold_run2");
        chk("hold_run2_z", z, 16'h0000);
        chk("hold_run2_flags", flags, 5'b01001);
        @(posedge clk); #1;
        chk("idle_after_run2", {busy, done}, 2'b00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/serial_sub_flags.md
Name: serial_sub_flags

Overview:
- Bit-serial 16-bit subtractor with a start/done handshake. It computes z = x - y LSB-first, one bit per clock.
- Produces the same five status flags as the team's combinational adder: sign, zero, overflow, carry (borrow), parity.
- Serves as the subtract-direction counterpart of that adder in area-constrained datapaths, where a result every WIDTH cycles is acceptable.

Parameters:
- WIDTH, 16, operand/result width in bits; legal values 2..32; counter sized to hold WIDTH-1.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only while idle.
- x  input  WIDTH  minuend; captured on the accepting edge.
- y  input  WIDTH  subtrahend; captured on the accepting edge.
- busy  output  1  high while a subtraction is in progress.
- done  output  1  one-cycle pulse: z and flags have just been updated.
- z  output  WIDTH  registered difference, x - y mod 2^WIDTH.
- sign  output  1  z[WIDTH-1].
- zero  output  1  1 when z == 0.
- overflow  output  1  signed overflow: x[MSB] != y[MSB] and z[MSB] != x[MSB].
- carry  output  1  borrow out: 1 when x < y unsigned.
- parity  output  1  XNOR-reduction of z: 1 when z has an even number of ones.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state IDLE; busy = done = 0; z = 0; all five flags = 0 (zero flag is 0 at reset even though z = 0).
  - working registers and bit counter cleared.
- States:
  - IDLE: wait for start.
  - RUN: process one bit per edge.
- IDLE -> RUN:
  - Edge k with start = 1: copy x and y into internal shift registers, borrow = 0, count = 0.
  - busy = 1 after edge k.
- RUN, each edge:
  - Take d = a0 ^ b0 ^ borrow and borrow' = (~a0 & b0) | (~(a0 ^ b0) & borrow) from the operand LSBs.
  - Shift d into the result shift register from the MSB end; shift both operand registers right; count++.
- Final RUN edge (k+WIDTH, count == WIDTH-1):
  - Load z and all flags from the completed result in the same edge.
  - carry = final borrow'. overflow uses the captured operand MSBs, held in dedicated registers.
  - done = 1 and busy = 0 for exactly the cycle following edge k+WIDTH; state -> IDLE.
- Latency:
  - Result visible WIDTH cycles after the accepting edge.
  - Throughput is one operation per WIDTH+1 cycles: start accepted at edge k+WIDTH+1 begins the next operation with no bubble beyond that.
- Between operations:
  - z and flags are stable from one done until the next done; they never change mid-RUN.
- start while busy:
  - Ignored entirely; no operand capture, no queueing.
  - start held high continuously restarts at each IDLE edge.
- Reset mid-RUN:
  - Aborts; no done is produced; all outputs return to reset values (previous result lost).
- x/y changes during RUN have no effect.
- done never asserts without a preceding accepted start.

Test Plan:
- Reset, then start with x=16'h0005, y=16'h0003 -> busy 1 for 16 cycles; done pulses exactly 16 edges after the accepting edge. Result: z=16'h0002, sign=0, zero=0, overflow=0, carry=0, parity=0.
- x=16'h1234, y=16'h1234 -> z=16'h0000, zero=1, parity=1, sign/overflow/carry=0.
- x=16'h0000, y=16'h0001 -> z=16'hffff, sign=1, carry=1, overflow=0, parity=1, zero=0.
- x=16'h8000, y=16'h0001 -> z=16'h7fff, overflow=1, sign=0, carry=0, parity=0.
- Edge case: x=16'h7fff, y=16'hffff -> z=16'h8000, overflow=1, carry=1, sign=1.
- Handshake:
  - Hold start=1 with x=16'h0005, y=16'h0003 at acceptance, then change x/y to 16'hffff mid-run -> result still 16'h0002.
  - A second start at the edge after done is accepted and produces its own done 16 edges later.
  - Outputs stay stable through the second run until its done.
- Reset mid-operation:
  - Start x=16'h0005, y=16'h0003, pulse rst_n low after 8 RUN edges -> busy=0, done=0, z=0, all flags 0 immediately (asynchronously); no done follows.
  - A fresh start then yields the correct result.
